// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART channel.
// UART_PARITY_EN adds the PARITY states to both FSM encodings.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_t;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_t;
`else
  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxStop} tx_state_t;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop} rx_state_t;
`endif

  // Clocks per oversample tick, never below one.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    int unsigned d;
    d = clk_freq / (baud_rate * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO; full/empty from an extra pointer bit.
// Drops pushes when full unless a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    count   = wr_ptr_q - rd_ptr_q;
    // Head reads as zero when empty so rx_data has a defined reset value.
    head    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_duplex_core.sv
// One UART channel: valid/ready transmitter, 16x oversampling receiver, RX FIFO.
// Define UART_PARITY_EN for an even-parity bit and the parity_err output.
module uart_duplex_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 19200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_done,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_overrun,
`ifdef UART_PARITY_EN
  output logic                          parity_err,
`endif
  output logic                          frame_err
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BW  = $clog2(DATA_BITS);
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  // Free-running tick generator
  logic [DW-1:0] div_cnt_q;
  logic          tick;

  assign tick = (div_cnt_q == DW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_cnt_q <= '0;
    else     div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;
  end

  // Transmitter
  tx_state_t            tx_state_q;
  logic [3:0]           tx_tick_q;
  logic [BW-1:0]        tx_bit_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_q, tx_done_q;
`ifdef UART_PARITY_EN
  logic                 tx_par_q;
`endif

  assign tx_ready = (tx_state_q == TxIdle);
  assign tx       = tx_q;
  assign tx_done  = tx_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TxIdle;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_done_q <= 1'b0;
      case (tx_state_q)
        TxIdle: begin
          if (tx_valid) begin
            tx_shift_q <= tx_data;
`ifdef UART_PARITY_EN
            tx_par_q   <= ^tx_data;
`endif
            tx_q       <= 1'b0;
            tx_tick_q  <= '0;
            tx_state_q <= TxStart;
          end
        end
        TxStart: begin
          if (tick) begin
            tx_tick_q <= tx_tick_q + 1'b1;
            if (tx_tick_q == TICK_LAST) begin
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[DATA_BITS-1:1]};
              tx_bit_q   <= '0;
              tx_state_q <= TxData;
            end
          end
        end
        TxData: begin
          if (tick) begin
            tx_tick_q <= tx_tick_q + 1'b1;
            if (tx_tick_q == TICK_LAST) begin
              if (tx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
                tx_q       <= tx_par_q;
                tx_state_q <= TxParity;
`else
                tx_q       <= 1'b1;
                tx_state_q <= TxStop;
`endif
              end else begin
                tx_q       <= tx_shift_q[0];
                tx_shift_q <= {1'b0, tx_shift_q[DATA_BITS-1:1]};
                tx_bit_q   <= tx_bit_q + 1'b1;
              end
            end
          end
        end
`ifdef UART_PARITY_EN
        TxParity: begin
          if (tick) begin
            tx_tick_q <= tx_tick_q + 1'b1;
            if (tx_tick_q == TICK_LAST) begin
              tx_q       <= 1'b1;
              tx_state_q <= TxStop;
            end
          end
        end
`endif
        TxStop: begin
          if (tick) begin
            tx_tick_q <= tx_tick_q + 1'b1;
            if (tx_tick_q == TICK_LAST) begin
              tx_done_q  <= 1'b1;
              tx_state_q <= TxIdle;
            end
          end
        end
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

  // Receiver: rx_s2_q is the synchronized line, rx_s3_q its previous value
  logic rx_s1_q, rx_s2_q, rx_s3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  rx_state_t            rx_state_q;
  logic [3:0]           rx_tick_q;
  logic [BW-1:0]        rx_bit_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic                 frame_err_q, rx_overrun_q;
  logic                 stop_sample, par_ok, rx_push;
  logic                 fifo_full, fifo_empty;
`ifdef UART_PARITY_EN
  logic                 rx_par_bad_q, parity_err_q;
  assign par_ok     = !rx_par_bad_q;
  assign parity_err = parity_err_q;
`else
  assign par_ok     = 1'b1;
`endif

  always_comb begin
    stop_sample = (rx_state_q == RxStop) && tick && (rx_tick_q == TICK_LAST);
    rx_push     = stop_sample && rx_s2_q && par_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q   <= RxIdle;
      rx_tick_q    <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      frame_err_q  <= 1'b0;
      rx_overrun_q <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q  <= 1'b0;
      rx_overrun_q <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (rx_state_q)
        RxIdle: begin
          if (rx_s3_q && !rx_s2_q) begin
            rx_tick_q  <= '0;
            rx_state_q <= RxStart;
          end
        end
        RxStart: begin
          if (tick) begin
            rx_tick_q <= rx_tick_q + 1'b1;
            if (rx_tick_q == TICK_MID) begin
              if (rx_s2_q) begin
                rx_state_q <= RxIdle;  // glitch, not a start bit
              end else begin
                rx_tick_q  <= '0;
                rx_bit_q   <= '0;
                rx_state_q <= RxData;
              end
            end
          end
        end
        RxData: begin
          if (tick) begin
            rx_tick_q <= rx_tick_q + 1'b1;
            if (rx_tick_q == TICK_LAST) begin
              rx_shift_q <= {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
              if (rx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
                rx_state_q <= RxParity;
`else
                rx_state_q <= RxStop;
`endif
              end else begin
                rx_bit_q <= rx_bit_q + 1'b1;
              end
            end
          end
        end
`ifdef UART_PARITY_EN
        RxParity: begin
          if (tick) begin
            rx_tick_q <= rx_tick_q + 1'b1;
            if (rx_tick_q == TICK_LAST) begin
              rx_par_bad_q <= rx_s2_q ^ (^rx_shift_q);
              rx_state_q   <= RxStop;
            end
          end
        end
`endif
        RxStop: begin
          if (tick) begin
            rx_tick_q <= rx_tick_q + 1'b1;
            if (rx_tick_q == TICK_LAST) begin
              frame_err_q  <= !rx_s2_q;
              rx_overrun_q <= rx_push && fifo_full && !rx_ready;
`ifdef UART_PARITY_EN
              parity_err_q <= rx_par_bad_q;
`endif
              rx_state_q   <= RxIdle;
            end
          end
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  assign frame_err  = frame_err_q;
  assign rx_overrun = rx_overrun_q;
  assign rx_valid   = !fifo_empty;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (rx_shift_q),
    .pop       (rx_ready),
    .head      (rx_data),
    .count     (rx_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
